// File: rtl/mem_pkg.sv
// Shared types and constants for the memory request path in front of mem_cntrl.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 24;
  localparam int MEM_DATA_WIDTH = 16;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Reads are fall-through: head_data shows the oldest entry.
// A push while full is dropped, and a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // DEPTH is a power of two, so the pointers wrap on their own.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Buffered request front-end for mem_cntrl: request FIFO, credit-gated read issue,
// and an in-order response FIFO. ADDR_WIDTH/DATA_WIDTH must match mem_pkg.
module mem_req_queue
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_rdy,
  input  logic                  mem_cplt,
  output logic                  busy,
  output logic                  err_unexp
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; the client must hold valid and payload steady until then. ready
  // is computed from registered state only, never from same-cycle valid.

  mem_req_t        req_in, req_head;
  logic            req_push, req_pop, req_full, req_empty;
  logic [CW-1:0]   req_count;
  logic            rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [CW-1:0]   rsp_count;
  logic [CW-1:0]   out_q, out_d;
  logic            err_q, err_d;
  logic            credit_ok, read_pop, cplt_ok;

  always_comb begin
    req_in       = '0;
    req_in.we    = req_we;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
  end

  assign req_ready = ~req_full;
  assign req_push  = req_valid & req_ready;

  sync_fifo #(.WIDTH($bits(mem_req_t)), .DEPTH(DEPTH)) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_push),
    .push_data (req_in),
    .pop       (req_pop),
    .head_data (req_head),
    .full      (req_full),
    .empty     (req_empty),
    .count     (req_count)
  );

  // A read may issue only if its data is guaranteed a response slot.
  assign credit_ok   = ({1'b0, out_q} + {1'b0, rsp_count}) < (CW+1)'(DEPTH);
  assign mem_addr    = req_head.addr;
  assign mem_data_in = req_head.wdata;
  assign mem_w_en    = ~req_empty & req_head.we;
  assign mem_r_en    = ~req_empty & ~req_head.we & credit_ok;
  assign req_pop     = mem_rdy & (mem_r_en | mem_w_en);
  assign read_pop    = mem_rdy & mem_r_en;
  assign cplt_ok     = mem_cplt & (out_q != '0);

  always_comb begin
    out_d = out_q;
    case ({read_pop, cplt_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    err_d = err_q | (mem_cplt & (out_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign rsp_push = cplt_ok;
  assign rsp_pop  = rsp_valid & rsp_ready;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (mem_data_out),
    .pop       (rsp_pop),
    .head_data (rsp_rdata),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  assign rsp_valid = ~rsp_empty;
  assign busy      = ~req_empty | (out_q != '0);
  assign err_unexp = err_q;

`ifndef SYNTHESIS
  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_push && rsp_full));
  a_out_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(read_pop && !cplt_ok && out_q == CW'(DEPTH)));
  a_out_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(cplt_ok && !read_pop && out_q == '0));
  a_req_count_range: assert property (@(posedge clk) disable iff (rst) req_count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: scoreboard queues for commands and read data,
// checked by a negedge monitor, plus directed checks of status outputs.
module tb_mem_req_queue;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic [23:0] mem_addr;
  logic [15:0] mem_data_in, mem_data_out;
  logic        mem_r_en, mem_w_en, mem_rdy, mem_cplt, busy, err_unexp;

  int errors = 0;
  int checks = 0;
  int cmd_cnt = 0;
  int base;

  logic [40:0] exp_cmd_q[$];
  logic [15:0] exp_rsp_q[$];

  mem_req_queue #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_data_out(mem_data_out), .mem_rdy(mem_rdy), .mem_cplt(mem_cplt),
    .busy(busy), .err_unexp(err_unexp)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rdy && (mem_r_en || mem_w_en)) begin
        cmd_cnt++;
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got %0h required none", {mem_w_en, mem_addr, mem_data_in});
        end else begin
          logic [40:0] e;
          e = exp_cmd_q.pop_front();
          if ({mem_w_en, mem_addr, mem_data_in} !== e || (mem_r_en === mem_w_en)) begin
            errors++;
            $display("FAIL cmd_order: got we=%0b r=%0b addr=%0h data=%0h required %0h",
                     mem_w_en, mem_r_en, mem_addr, mem_data_in, e);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got %0h required none", rsp_rdata);
        end else begin
          logic [15:0] r;
          r = exp_rsp_q.pop_front();
          if (rsp_rdata !== r) begin
            errors++;
            $display("FAIL rsp_data: got %0h required %0h", rsp_rdata, r);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [23:0] a, input logic [15:0] d,
                          input logic [15:0] rd, input bit track);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    if (track) begin
      exp_cmd_q.push_back({we, a, d});
      if (!we) exp_rsp_q.push_back(rd);
    end
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("push_timeout", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic cplt_burst(input int n, input logic [15:0] d0);
    for (int i = 0; i < n; i++) begin
      mem_cplt = 1'b1;
      mem_data_out = d0 + 16'(i);
      tick();
    end
    mem_cplt = 1'b0;
  endtask

  task automatic drain_rsp();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while (rsp_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("drain_timeout", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("idle_timeout", 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mem_data_out = '0; mem_rdy = 1'b0; mem_cplt = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_r_en", 64'(mem_r_en), 64'(0));
    check("rst_w_en", 64'(mem_w_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_unexp), 64'(0));
    tick();

    // Single write, accepted two cycles after it appears
    push_req(1'b1, 24'h000010, 16'hBEEF, 16'h0, 1'b1);
    @(negedge clk);
    check("wr_w_en", 64'(mem_w_en), 64'(1));
    check("wr_addr", 64'(mem_addr), 64'h000010);
    check("wr_data", 64'(mem_data_in), 64'hBEEF);
    check("wr_busy", 64'(busy), 64'(1));
    tick();
    check("wr_w_en_hold", 64'(mem_w_en), 64'(1));
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    @(negedge clk);
    check("wr_w_en_drop", 64'(mem_w_en), 64'(0));
    check("wr_busy_drop", 64'(busy), 64'(0));
    tick();

    // Single read with completion three cycles after issue
    push_req(1'b0, 24'h000020, 16'h0, 16'h1234, 1'b1);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    tick(2);
    check("rd_busy_outstanding", 64'(busy), 64'(1));
    check("rd_no_rsp_yet", 64'(rsp_valid), 64'(0));
    cplt_burst(1, 16'h1234);
    @(negedge clk);
    check("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    check("rd_rsp_data", 64'(rsp_rdata), 64'h1234);
    check("rd_busy_done", 64'(busy), 64'(0));
    drain_rsp();

    // Credit exhaustion: eight reads, only four may issue
    base = cmd_cnt;
    mem_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      push_req(1'b0, 24'h000100 + 24'(i), 16'h0, 16'hA000 + 16'(i), 1'b1);
    @(negedge clk);
    check("cr_issued4", 64'(cmd_cnt - base), 64'(4));
    check("cr_r_en_blocked", 64'(mem_r_en), 64'(0));
    check("cr_req_full", 64'(req_ready), 64'(0));
    tick();
    cplt_burst(4, 16'hA000);
    @(negedge clk);
    check("cr_still_blocked", 64'(mem_r_en), 64'(0));
    check("cr_rsp_valid", 64'(rsp_valid), 64'(1));
    for (int k = 0; k < 4; k++) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick(3);
      check("cr_one_per_pop", 64'(cmd_cnt - base), 64'(5 + k));
    end
    check("cr_req_ready_back", 64'(req_ready), 64'(1));
    cplt_burst(4, 16'hA004);
    drain_rsp();
    @(negedge clk);
    check("cr_idle", 64'(busy), 64'(0));
    tick();

    // Write behind a credit-blocked read must wait
    for (int i = 0; i < 4; i++)
      push_req(1'b0, 24'h000200 + 24'(i), 16'h0, 16'hB000 + 16'(i), 1'b1);
    tick(2);
    cplt_burst(4, 16'hB000);
    base = cmd_cnt;
    push_req(1'b1, 24'h000300, 16'h3333, 16'h0, 1'b1);
    push_req(1'b0, 24'h000301, 16'h0, 16'hC301, 1'b1);
    push_req(1'b1, 24'h000302, 16'h4444, 16'h0, 1'b1);
    tick(2);
    check("ord_first_write", 64'(cmd_cnt - base), 64'(1));
    check("ord_w_en_held", 64'(mem_w_en), 64'(0));
    check("ord_r_en_held", 64'(mem_r_en), 64'(0));
    check("ord_head_addr", 64'(mem_addr), 64'h000301);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick(3);
    check("ord_all_issued", 64'(cmd_cnt - base), 64'(3));
    check("ord_busy_rd", 64'(busy), 64'(1));
    mem_rdy = 1'b0;
    cplt_burst(1, 16'hC301);
    drain_rsp();
    @(negedge clk);
    check("ord_idle", 64'(busy), 64'(0));
    tick();

    // Fill the request FIFO without mem_rdy
    for (int i = 0; i < 4; i++)
      push_req(1'b1, 24'h000400 + 24'(i), 16'h5000 + 16'(i), 16'h0, 1'b1);
    @(negedge clk);
    check("full_req_ready", 64'(req_ready), 64'(0));
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000404; req_wdata = 16'h5004;
    exp_cmd_q.push_back({1'b1, 24'h000404, 16'h5004});
    tick();
    check("full_5th_held", 64'(req_ready), 64'(0));
    check("full_head", 64'(mem_addr), 64'h000400);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    @(negedge clk);
    check("full_ready_after_pop", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    mem_rdy = 1'b1;
    wait_idle();
    mem_rdy = 1'b0;
    tick();

    // Unexpected completion, then reset clears everything
    mem_data_out = 16'hDEAD;
    cplt_burst(1, 16'hDEAD);
    @(negedge clk);
    check("unexp_err", 64'(err_unexp), 64'(1));
    check("unexp_no_rsp", 64'(rsp_valid), 64'(0));
    tick(2);
    check("unexp_sticky", 64'(err_unexp), 64'(1));
    push_req(1'b1, 24'h000500, 16'h6000, 16'h0, 1'b0);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_err", 64'(err_unexp), 64'(0));
    check("post_rst_ready", 64'(req_ready), 64'(1));
    check("post_rst_w_en", 64'(mem_w_en), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_rsp", 64'(rsp_valid), 64'(0));
    tick();

    // Final report
    check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'(0));
    check("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
